// File: rtl/serializer.sv
// Parallel-in, serial-out stage feeding a serial-in shift register.
// A word is taken on a valid/ready handshake and emitted one bit per enable strobe.
module serializer #(
  parameter int unsigned width_p     = 5,
  parameter bit          msb_first_p = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [width_p-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               ready_i,
  output logic               data_o,
  output logic               enable_o,
  output logic               last_o
);

  localparam int unsigned    CntW    = (width_p > 1) ? $clog2(width_p) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(width_p - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e              state_q, state_d;
  logic [width_p-1:0]  word_q, word_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                in_shift, last, xfer, accept;

  always_comb begin
    in_shift = (state_q == StShift);
    last     = in_shift && (cnt_q == LastCnt);
    xfer     = in_shift && ready_i;
    // ready_i feeds ready_o combinationally so back-to-back words have no bubble.
    ready_o  = (state_q == StIdle) || (last && ready_i);
    accept   = valid_i && ready_o;
    enable_o = xfer;
    last_o   = last;
    data_o   = 1'b0;
    if (in_shift) begin
      if (msb_first_p) begin
        data_o = word_q[width_p-1];
      end else begin
        data_o = word_q[0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = StShift;
      word_d  = data_i;
      cnt_d   = '0;
    end else if (xfer) begin
      if (msb_first_p) begin
        word_d = {word_q[width_p-2:0], 1'b0};
      end else begin
        word_d = {1'b0, word_q[width_p-1:1]};
      end
      cnt_d = cnt_q + CntW'(1);
      if (last) begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against an index-based word model plus literal sequences.
module tb_serializer;

  localparam int W = 5;

  logic         clk_i = 1'b0;
  logic         reset_ni;
  logic [W-1:0] data_i;
  logic         valid_i;
  logic         ready_i;
  logic         m_ready, m_data, m_en, m_last;
  logic         l_ready, l_data, l_en, l_last;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  serializer #(.width_p(W), .msb_first_p(1'b1)) u_msb (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (m_ready),
    .ready_i  (ready_i),
    .data_o   (m_data),
    .enable_o (m_en),
    .last_o   (m_last)
  );

  serializer #(.width_p(W), .msb_first_p(1'b0)) u_lsb (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (l_ready),
    .ready_i  (ready_i),
    .data_o   (l_data),
    .enable_o (l_en),
    .last_o   (l_last)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: the word being sent plus the index of the bit now on the wire.
  logic [W-1:0] mw;
  int           mi;
  bit           mbusy;

  always @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mbusy = 1'b0;
      mi    = 0;
      mw    = '0;
    end else begin
      if (valid_i && (!mbusy || (mi == W - 1 && ready_i))) begin
        mw    = data_i;
        mi    = 0;
        mbusy = 1'b1;
      end else if (mbusy && ready_i) begin
        mi++;
        if (mi == W) mbusy = 1'b0;
      end
    end
  end

  always @(negedge clk_i) begin
    logic e_en, e_last, e_rdy, e_m, e_l;
    if (reset_ni) begin
      e_en   = mbusy && ready_i;
      e_last = mbusy && (mi == W - 1);
      e_rdy  = !mbusy || (e_last && ready_i);
      e_m    = mbusy ? mw[W-1-mi] : 1'b0;
      e_l    = mbusy ? mw[mi] : 1'b0;
      check("msb_ready", 32'(m_ready), 32'(e_rdy));
      check("msb_enable", 32'(m_en), 32'(e_en));
      check("msb_last", 32'(m_last), 32'(e_last));
      check("msb_data", 32'(m_data), 32'(e_m));
      check("lsb_ready", 32'(l_ready), 32'(e_rdy));
      check("lsb_enable", 32'(l_en), 32'(e_en));
      check("lsb_last", 32'(l_last), 32'(e_last));
      check("lsb_data", 32'(l_data), 32'(e_l));
    end
  end

  // Recorder of enabled bits; shreg mimics the downstream shift register.
  logic [31:0]  seq_m, seq_l, seq_last, seq_rdy;
  logic [W-1:0] shreg = '0;
  int           n_en, first_en, last_en;

  always @(negedge clk_i) begin
    if (m_en) begin
      seq_m    = {seq_m[30:0], m_data};
      seq_last = {seq_last[30:0], m_last};
      seq_rdy  = {seq_rdy[30:0], m_ready};
      shreg    = {shreg[W-2:0], m_data};
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
      n_en++;
    end
    if (l_en) seq_l = {seq_l[30:0], l_data};
  end

  task automatic clear_rec();
    seq_m    = '0;
    seq_l    = '0;
    seq_last = '0;
    seq_rdy  = '0;
    n_en     = 0;
    first_en = -1;
    last_en  = -1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    data_i  = w;
    valid_i = 1'b1;
    for (int k = 0; k < 50 && !m_ready; k++) tick();
    check("send_ready_wait", 32'(m_ready), 32'd1);
    tick();
    valid_i = 1'b0;
    data_i  = W'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    clear_rec();
    reset_ni = 1'b0;
    valid_i  = 1'b0;
    data_i   = '0;
    ready_i  = 1'b1;
    #1;
    check("rst_ready", 32'(m_ready), 32'd1);
    check("rst_enable", 32'(m_en), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    repeat (2) tick();
    reset_ni = 1'b1;
    tick();

    // Single word, both bit orders.
    clear_rec();
    send(5'b10110);
    repeat (6) tick();
    check("t1_seq_msb", seq_m[4:0], 32'b10110);
    check("t1_seq_lsb", seq_l[4:0], 32'b01101);
    check("t1_last", seq_last[4:0], 32'b00001);
    check("t1_n_en", 32'(n_en), 32'd5);
    check("t1_span", 32'(last_en - first_en), 32'd4);
    check("t1_shreg", 32'(shreg), 32'b10110);

    // Back-to-back words with valid held.
    clear_rec();
    data_i  = 5'b11001;
    valid_i = 1'b1;
    tick();
    data_i  = 5'b00111;
    for (int k = 0; k < 20 && !m_ready; k++) tick();
    check("t3_ready_wait", 32'(m_ready), 32'd1);
    tick();
    valid_i = 1'b0;
    repeat (8) tick();
    check("t3_seq", seq_m[9:0], 32'b1100100111);
    check("t3_n_en", 32'(n_en), 32'd10);
    check("t3_span", 32'(last_en - first_en), 32'd9);
    check("t3_ready", seq_rdy[9:0], 32'b0000100001);
    check("t3_last", seq_last[9:0], 32'b0000100001);

    // Upstream changes data_i while waiting; only the value at the last edge counts.
    clear_rec();
    data_i  = 5'b10011;
    valid_i = 1'b1;
    tick();
    for (int k = 0; k < 20 && !m_ready; k++) begin
      data_i = W'($urandom);
      tick();
    end
    data_i = 5'b01101;
    check("t6_ready_wait", 32'(m_ready), 32'd1);
    tick();
    valid_i = 1'b0;
    data_i  = W'($urandom);
    repeat (7) tick();
    check("t6_seq", seq_m[9:0], 32'b1001101101);
    check("t6_n_en", 32'(n_en), 32'd10);

    // Three stall cycles while the 2nd bit is on the wire.
    clear_rec();
    send(5'b10110);
    tick();
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_stall_data", 32'(m_data), 32'd0);
      check("t4_stall_en", 32'(m_en), 32'd0);
      tick();
    end
    ready_i = 1'b1;
    repeat (6) tick();
    check("t4_seq", seq_m[4:0], 32'b10110);
    check("t4_n_en", 32'(n_en), 32'd5);
    check("t4_span", 32'(last_en - first_en), 32'd7);

    // Reset mid-word aborts immediately, then a fresh word goes through.
    clear_rec();
    send(5'b10110);
    repeat (3) tick();
    check("t5_pre_en", 32'(m_en), 32'd1);
    check("t5_pre_data", 32'(m_data), 32'd1);
    #2;
    reset_ni = 1'b0;
    #1;
    check("t5_async_en", 32'(m_en), 32'd0);
    check("t5_async_data", 32'(m_data), 32'd0);
    check("t5_async_last", 32'(m_last), 32'd0);
    check("t5_async_ready", 32'(m_ready), 32'd1);
    repeat (2) tick();
    reset_ni = 1'b1;
    clear_rec();
    repeat (3) tick();
    check("t5_no_en", 32'(n_en), 32'd0);
    check("t5_ready", 32'(m_ready), 32'd1);
    send(5'b01010);
    repeat (6) tick();
    check("t5_seq", seq_m[4:0], 32'b01010);
    check("t5_seq_lsb", seq_l[4:0], 32'b01010);
    check("t5_n_en", 32'(n_en), 32'd5);
    check("t5_shreg", 32'(shreg), 32'b01010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serializer.md
# serializer

Parallel-in, serial-out stage that feeds the team's serial-in shift register. It accepts a `width_p`-bit word on a valid/ready handshake and emits it one bit per transfer cycle. Each bit is qualified by an enable strobe that drives the shift register's `enable_i` directly. With `msb_first_p=1`, after `width_p` strobes the downstream register holds the word with bit i at its `data_o[i]`.

## Interface
- `width_p`, default 5: word width. Must be ≥ 2 and equal to the downstream shift depth.
- `msb_first_p`, default 1: 1 emits bit `width_p-1` first; 0 emits bit 0 first.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `reset_ni`  in  1  one clock; reset is asynchronous and active-low.
- `data_i`  in  `width_p`  parallel word, sampled on accept.
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  block can accept a word this cycle.
- `ready_i`  in  1  downstream may take a bit this cycle; tie to 1 when unused.
- `data_o`  out  1  current serial bit.
- `enable_o`  out  1  bit transfer strobe; drives the shift register's `enable_i`.
- `last_o`  out  1  current bit is the final bit of the word.

## Operation
- State: FSM {IDLE, SHIFT}, word register `word_q[width_p]`, bit counter `cnt_q` (`$clog2(width_p)` bits).
- Reset (async assert, sync release) sets:
  - state IDLE, `word_q`=0, `cnt_q`=0;
  - `data_o`=0, `enable_o`=0, `last_o`=0, `ready_o`=1.
- Accept: occurs when `valid_i & ready_o` at a rising edge. On accept:
  - `word_q <= data_i`;
  - `cnt_q <= 0`;
  - state goes to SHIFT.
- IDLE outputs: `ready_o`=1, `enable_o`=0, `data_o`=0, `last_o`=0.
- SHIFT outputs:
  - `data_o` = `word_q[width_p-1]` if `msb_first_p`, else `word_q[0]`.
  - `enable_o` = `ready_i`.
  - `last_o` = (`cnt_q == width_p-1`).
- Transfer: a SHIFT cycle with `ready_i`=1. On transfer:
  - `word_q` shifts one position toward the emitting end, zero-fill;
  - `cnt_q` increments.
- Stall: with `ready_i`=0 in SHIFT, all state holds and `data_o` stays stable. No bit is lost or duplicated.
- Word end: transfer while `last_o`=1.
  - If `valid_i`=1 in the same cycle, the new word is accepted back-to-back. State stays SHIFT, `cnt_q` goes to 0, and `word_q` loads `data_i`.
  - Otherwise state goes to IDLE.
- `ready_o` = IDLE | (SHIFT & `last_o` & `ready_i`). This is a combinational path from `ready_i` to `ready_o`; that path is deliberate.
- `data_i` is ignored when not accepting. `valid_i` asserted in SHIFT before the last bit waits; the upstream must hold `data_i`/`valid_i` until accept.
- Reset asserted mid-word aborts the word immediately. Outputs take reset values asynchronously, and no further `enable_o` pulses occur.

## Timing
- Accept at edge k: first bit on `data_o` with `enable_o`=1 in cycle k+1, given `ready_i`=1.
- No stalls: exactly `width_p` consecutive `enable_o` cycles per word. `last_o` is high in the `width_p`-th of them.
- Throughput:
  - back-to-back words give 100% `enable_o` duty, with no bubble between words;
  - a word arriving while IDLE costs one accept cycle.
- Each stalled cycle (`ready_i`=0) extends the word by one cycle.
- All outputs except `ready_o`/`enable_o` are registered-state functions. Those two also depend on `ready_i`.

## Test plan
- Reset, then `width_p`=5, `msb_first_p`=1, accept 5'b10110 with `ready_i`=1 → `data_o` = 1,0,1,1,0 on 5 consecutive `enable_o` cycles. `last_o` is high on the 5th. A connected `shift` instance then reads `data_o`=5'b10110.
- Same word with `msb_first_p`=0 → `data_o` sequence 0,1,1,0,1.
- Words 5'b11001 then 5'b00111, `valid_i` held high → 10 consecutive `enable_o` cycles. `ready_o` is high only in the cycle `last_o` is high. Sequence is 1,1,0,0,1,0,0,1,1,1.
- `ready_i` low for 3 cycles after the 2nd bit of 5'b10110 → `data_o` holds 0 for those cycles with `enable_o`=0. The sequence then completes; total word time is 8 cycles.
- `reset_ni` pulsed low after the 3rd bit → `enable_o`, `data_o`, `last_o` drop to 0 without waiting for a clock. After release `ready_o`=1, and a new word 5'b01010 serializes correctly from bit 4.
- `valid_i`=1 held during SHIFT with `data_i` changing → data is sampled only at the `last_o` transfer edge. Intermediate values are never emitted.
